cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 126 ++++++++++++
 tb/tb_cpu_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: FETCH/DECODE/MEMWAIT/EXEC control FSM with memory-wait fault and retired-instruction counter.
// Optional single-step support is enabled by defining LUNA_SINGLE_STEP_EN.
module cpu_sequencer #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_halt_req,
    input  logic        i_step,
    input  logic        i_uses_m,
    input  logic        i_jump_take,
    input  logic        i_dest_a,
    input  logic        i_dest_d,
    input  logic        i_dest_m,
    input  logic        i_mem_ack,
    output logic        o_ir_load,
    output logic        o_reg_a_en,
    output logic        o_reg_d_en,
    output logic        o_reg_m_en,
    output logic        o_pc_write,
    output logic        o_pc_inc,
    output logic        o_mem_req,
    output logic [2:0]  o_state,
    output logic        o_halted,
    output logic        o_fault,
    output logic [15:0] o_instr_count
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_MEMWAIT = 3'd3,
        S_EXEC    = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(WAIT_MAX - 1);

    state_t      r_state, w_next;
    logic [7:0]  r_wait;
    logic [15:0] r_instr_count;
    logic        r_ir_load, r_reg_a_en, r_reg_d_en, r_reg_m_en;
    logic        r_pc_write, r_pc_inc, r_mem_req, r_halted, r_fault;
    logic        w_launch, w_step_active;

`ifdef LUNA_SINGLE_STEP_EN
    logic r_step;
    assign w_launch      = (i_start || i_step) && !i_halt_req;
    assign w_step_active = r_step;
    // flag only changes while idle, so it holds for the whole stepped instruction
    always_ff @(posedge clk) begin
        if (rst)
            r_step <= 1'b0;
        else if (r_state == S_IDLE)
            r_step <= i_step && !i_halt_req;
    end
`else
    logic w_unused_step;
    assign w_unused_step = i_step;
    assign w_launch      = i_start && !i_halt_req;
    assign w_step_active = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = w_launch ? S_FETCH : S_IDLE;
            S_FETCH:   w_next = S_DECODE;
            S_DECODE:  w_next = i_uses_m ? S_MEMWAIT : S_EXEC;
            S_MEMWAIT: w_next = i_mem_ack ? S_EXEC : (r_wait == LP_LAST) ? S_FAULT : S_MEMWAIT;
            S_EXEC:    w_next = (i_halt_req || w_step_active) ? S_IDLE : S_FETCH;
            S_FAULT:   w_next = S_FAULT;
            default:   w_next = S_IDLE;
        endcase
    end

    // outputs are registered against the next state so they line up with o_state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir_load     <= 1'b0;
            r_reg_a_en    <= 1'b0;
            r_reg_d_en    <= 1'b0;
            r_reg_m_en    <= 1'b0;
            r_pc_write    <= 1'b0;
            r_pc_inc      <= 1'b0;
            r_mem_req     <= 1'b0;
            r_halted      <= 1'b1;
            r_fault       <= 1'b0;
            r_instr_count <= 16'd0;
            r_wait        <= 8'd0;
        end else begin
            r_ir_load  <= w_next == S_FETCH;
            r_reg_a_en <= w_next == S_EXEC && i_dest_a;
            r_reg_d_en <= w_next == S_EXEC && i_dest_d;
            r_reg_m_en <= w_next == S_EXEC && i_dest_m;
            r_pc_write <= w_next == S_EXEC && i_jump_take;
            r_pc_inc   <= w_next == S_EXEC && !i_jump_take;
            r_mem_req  <= w_next == S_MEMWAIT;
            r_halted   <= w_next == S_IDLE || w_next == S_FAULT;
            r_fault    <= w_next == S_FAULT;
            r_wait     <= (r_state == S_MEMWAIT && w_next == S_MEMWAIT) ? r_wait + 8'd1 : 8'd0;
            if (w_next == S_EXEC)
                r_instr_count <= r_instr_count + 16'd1;
        end
    end

    assign o_ir_load     = r_ir_load;
    assign o_reg_a_en    = r_reg_a_en;
    assign o_reg_d_en    = r_reg_d_en;
    assign o_reg_m_en    = r_reg_m_en;
    assign o_pc_write    = r_pc_write;
    assign o_pc_inc      = r_pc_inc;
    assign o_mem_req     = r_mem_req;
    assign o_state       = r_state;
    assign o_halted      = r_halted;
    assign o_fault       = r_fault;
    assign o_instr_count = r_instr_count;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed vector table plus hand-written multi-cycle sequences for cpu_sequencer.
module tb_cpu_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, halt_req = 1'b0, step = 1'b0, uses_m = 1'b0, jump_take = 1'b0;
    logic        dest_a = 1'b0, dest_d = 1'b0, dest_m = 1'b0, mem_ack = 1'b0;
    logic        ir_load, reg_a_en, reg_d_en, reg_m_en, pc_write, pc_inc, mem_req, halted, fault;
    logic [2:0]  state;
    logic [15:0] instr_count;
    int          n_tests = 0;
    int          n_fail = 0;
    int          nreq;

    cpu_sequencer #(.WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_halt_req(halt_req), .i_step(step),
        .i_uses_m(uses_m), .i_jump_take(jump_take), .i_dest_a(dest_a), .i_dest_d(dest_d),
        .i_dest_m(dest_m), .i_mem_ack(mem_ack), .o_ir_load(ir_load), .o_reg_a_en(reg_a_en),
        .o_reg_d_en(reg_d_en), .o_reg_m_en(reg_m_en), .o_pc_write(pc_write), .o_pc_inc(pc_inc),
        .o_mem_req(mem_req), .o_state(state), .o_halted(halted), .o_fault(fault),
        .o_instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // in  = {start, halt_req, step, uses_m, jump_take, dest_a, dest_d, dest_m, mem_ack}
    // out = {ir_load, reg_a_en, reg_d_en, reg_m_en, pc_write, pc_inc, mem_req, halted, fault}
    typedef struct {
        logic [8:0]  in;
        logic [2:0]  st;
        logic [8:0]  out;
        logic [15:0] cnt;
    } vec_t;

    vec_t tv [15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic set_in(input logic [8:0] v);
        {start, halt_req, step, uses_m, jump_take, dest_a, dest_d, dest_m, mem_ack} = v;
    endtask

    task automatic do_reset();
        set_in(9'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic enter_memwait();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        uses_m = 1'b1;
        tick();
    endtask

    initial begin
        tv[0]  = '{9'b000000000, 3'd0, 9'b000000010, 16'd0};
        tv[1]  = '{9'b100000000, 3'd1, 9'b100000000, 16'd0};
        tv[2]  = '{9'b000001000, 3'd2, 9'b000000000, 16'd0};
        tv[3]  = '{9'b000001000, 3'd4, 9'b010001000, 16'd1};
        tv[4]  = '{9'b100000000, 3'd1, 9'b100000000, 16'd1};
        tv[5]  = '{9'b000100000, 3'd2, 9'b000000000, 16'd1};
        tv[6]  = '{9'b000100000, 3'd3, 9'b000000100, 16'd1};
        tv[7]  = '{9'b100100000, 3'd3, 9'b000000100, 16'd1};
        tv[8]  = '{9'b000110011, 3'd4, 9'b000110000, 16'd2};
        tv[9]  = '{9'b010000000, 3'd0, 9'b000000010, 16'd2};
        tv[10] = '{9'b110000000, 3'd0, 9'b000000010, 16'd2};
        tv[11] = '{9'b100000000, 3'd1, 9'b100000000, 16'd2};
        tv[12] = '{9'b010000000, 3'd2, 9'b000000000, 16'd2};
        tv[13] = '{9'b010010100, 3'd4, 9'b001010000, 16'd3};
        tv[14] = '{9'b010000000, 3'd0, 9'b000000010, 16'd3};

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_state", {29'd0, state}, 32'd0);
        check("reset_flags", {ir_load, reg_a_en, reg_d_en, reg_m_en, pc_write, pc_inc, mem_req, halted, fault},
              9'b000000010);
        check("reset_count", instr_count, 16'd0);

        for (int i = 0; i < 15; i++) begin
            set_in(tv[i].in);
            tick();
            check($sformatf("vec%0d", i),
                  {state, ir_load, reg_a_en, reg_d_en, reg_m_en, pc_write, pc_inc, mem_req, halted, fault, instr_count},
                  {tv[i].st, tv[i].out, tv[i].cnt});
        end

        // four back-to-back register-only instructions
        do_reset();
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            start = 1'b0;
            check($sformatf("run_state_c%0d", c), {29'd0, state},
                  (c % 3 == 1) ? 32'd1 : (c % 3 == 2) ? 32'd2 : 32'd4);
            check($sformatf("run_irload_c%0d", c), {31'd0, ir_load}, {31'd0, c % 3 == 1});
        end
        check("run_count4", instr_count, 16'd4);

        // ack arrives in the fifth MEMWAIT cycle
        do_reset();
        enter_memwait();
        nreq = int'(mem_req);
        repeat (4) begin
            tick();
            nreq += int'(mem_req);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        uses_m = 1'b0;
        check("mem_req_cycles", nreq, 5);
        check("mem_exec_state", {29'd0, state}, 32'd4);
        check("mem_exec_pc", {30'd0, pc_write, pc_inc}, 32'b01);
        check("mem_exec_mreq", {31'd0, mem_req}, 32'd0);
        check("mem_count", instr_count, 16'd1);

        // no ack: fault after fifteen MEMWAIT cycles
        do_reset();
        enter_memwait();
        repeat (14) tick();
        check("wait15_state", {29'd0, state}, 32'd3);
        tick();
        check("fault_state", {29'd0, state}, 32'd5);
        check("fault_flags", {29'd0, fault, halted, mem_req}, 32'b110);
        start = 1'b1;
        step = 1'b1;
        tick();
        tick();
        check("fault_sticky", {29'd0, state}, 32'd5);
        start = 1'b0;
        step = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("fault_cleared", {28'd0, state, fault}, {28'd0, 3'd0, 1'b0});

        // ack coincident with expiry wins
        do_reset();
        enter_memwait();
        repeat (14) tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("ack_at_expiry", {29'd0, state}, 32'd4);
        check("ack_at_expiry_cnt", instr_count, 16'd1);

        // reset mid-handshake, then the wait counter must start fresh
        do_reset();
        enter_memwait();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_memwait", {state, mem_req, halted, fault, instr_count}, {3'd0, 3'b010, 16'd0});
        enter_memwait();
        repeat (14) tick();
        check("rst_wait_cleared", {29'd0, state}, 32'd3);

        // reset in EXEC with start asserted: reset wins
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        dest_a = 1'b1;
        tick();
        check("exec_before_rst", {state, reg_a_en, instr_count}, {3'd4, 1'b1, 16'd1});
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        dest_a = 1'b0;
        check("rst_exec", {state, reg_a_en, pc_inc, halted, instr_count}, {3'd0, 3'b001, 16'd0});

        // counter wrap
        do_reset();
        force dut.r_instr_count = 16'hFFFF;
        #1;
        release dut.r_instr_count;
        check("preset_ffff", instr_count, 16'hFFFF);
        start = 1'b1;
        tick();
        start = 1'b0;
        halt_req = 1'b1;
        tick();
        tick();
        check("wrap_exec", {29'd0, state}, 32'd4);
        check("wrap_count", instr_count, 16'h0000);
        tick();
        halt_req = 1'b0;
        check("wrap_halted", {28'd0, state, halted}, {28'd0, 3'd0, 1'b1});

        // single step
        do_reset();
        step = 1'b1;
        start = 1'b1;
        tick();
        step = 1'b0;
        start = 1'b0;
`ifdef LUNA_SINGLE_STEP_EN
        check("step_fetch", {29'd0, state}, 32'd1);
        tick();
        tick();
        check("step_exec", {state, instr_count}, {3'd4, 16'd1});
        tick();
        check("step_idle", {state, halted, instr_count}, {3'd0, 1'b1, 16'd1});
        tick();
        check("step_stays_idle", {29'd0, state}, 32'd0);
`else
        check("step_start_fetch", {29'd0, state}, 32'd1);
        do_reset();
        step = 1'b1;
        tick();
        tick();
        step = 1'b0;
        check("step_ignored", {state, halted, instr_count}, {3'd0, 1'b1, 16'd0});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
